// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter that time-shares a 2-bit 4:1 mux between requesters A..D,
// bounding each ownership to MAX_HOLD consecutive cycles.

module mux_4x1_2bit (
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [1:0] in_c,
    input  logic [1:0] in_d,
    input  logic [1:0] sel,
    output logic [1:0] y
);
    always_comb begin
        case (sel)
            2'b00:   y = in_a;
            2'b01:   y = in_b;
            2'b10:   y = in_c;
            default: y = in_d;
        endcase
    end
endmodule

module mux_4x1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic ReqA,
    input  logic ReqB,
    input  logic ReqC,
    input  logic ReqD,
    input  logic A1,
    input  logic A0,
    input  logic B1,
    input  logic B0,
    input  logic C1,
    input  logic C0,
    input  logic D1,
    input  logic D0,
    output logic GntA,
    output logic GntB,
    output logic GntC,
    output logic GntD,
    output logic S1,
    output logic S0,
    output logic Out1,
    output logic Out0,
    output logic Busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;

    logic [3:0]  req;
    logic [1:0]  scan_idx;
    logic [1:0]  pick_idx;
    logic        pick_found;
    logic [1:0]  mux_out;

    assign req = {ReqD, ReqC, ReqB, ReqA};

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // The select register doubles as the owner index: it is loaded on grant and
    // never changes while busy.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BUSY;
                    sel_d      = pick_idx;
                    gnt_d      = 4'b0001 << pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd1;
                    ptr_d      = pick_idx + 2'd1;
                end
            end
            default: begin
                if (!req[sel_q] || hold_cnt_q == 8'(MAX_HOLD)) begin
                    state_d    = IDLE;
                    gnt_d      = 4'b0000;
                    busy_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= 8'd0;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
        end
    end

    mux_4x1_2bit u_mux (
        .in_a (({A1, A0})),
        .in_b (({B1, B0})),
        .in_c (({C1, C0})),
        .in_d (({D1, D0})),
        .sel  (sel_q),
        .y    (mux_out)
    );

    assign {GntD, GntC, GntB, GntA} = gnt_q;
    assign {S1, S0}                 = sel_q;
    assign {Out1, Out0}             = mux_out;
    assign Busy                     = busy_q;
endmodule
